// File: rtl/switch_debouncer_pkg.sv
// Shared board constants for the switch debouncer and its users.
// The default sample divider gives a 1 ms debounce tick at the board clock.
package switch_debouncer_pkg;

  localparam int unsigned CLK_HZ         = 100_000_000;
  localparam int unsigned DEBOUNCE_HZ    = 1_000;
  localparam int unsigned SW_WIDTH       = 8;
  localparam int unsigned SAMPLE_DIV_DEF = CLK_HZ / DEBOUNCE_HZ;
  localparam int unsigned STABLE_DEF     = 4;

  // Width needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch bit: commits din to dout after STABLE_SAMPLES
// consecutive mismatching sample ticks.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = STABLE_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic commit
);

  localparam int unsigned       SW   = $clog2(STABLE_SAMPLES) + 1;
  localparam logic [SW-1:0]     LAST = SW'(STABLE_SAMPLES - 1);

  logic [SW-1:0] scnt_q, scnt_d;
  logic          dout_q, dout_d;

  always_comb begin
    scnt_d = scnt_q;
    dout_d = dout_q;
    commit = 1'b0;
    if (tick) begin
      if (din == dout_q) begin
        scnt_d = '0;
      end else if (scnt_q == LAST) begin
        dout_d = din;
        scnt_d = '0;
        commit = 1'b1;
      end else begin
        scnt_d = scnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt_q <= '0;
      dout_q <= 1'b0;
    end else begin
      scnt_q <= scnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the slide switches, flags value changes and
// reports when the post-reset settle window has elapsed.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH          = SW_WIDTH,
  parameter int unsigned SAMPLE_DIV     = SAMPLE_DIV_DEF,
  parameter int unsigned STABLE_SAMPLES = STABLE_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed,
  output logic             sw_valid
);

  localparam int unsigned   PW    = cnt_width(SAMPLE_DIV);
  localparam logic [PW-1:0] PLAST = PW'(SAMPLE_DIV - 1);
  localparam int unsigned   TW    = $clog2(STABLE_SAMPLES + 1);
  localparam logic [TW-1:0] TMAX  = TW'(STABLE_SAMPLES);
  localparam logic [TW-1:0] TLAST = TW'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [TW-1:0]    settle_q, settle_d;
  logic             valid_q, valid_d;
  logic             changed_q;
  logic             tick;
  logic [WIDTH-1:0] commit;

  assign tick = (pcnt_q == PLAST);

  always_comb begin
    pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
    settle_d = settle_q;
    valid_d  = valid_q;
    if (tick && settle_q != TMAX) begin
      settle_d = settle_q + TW'(1);
    end
    // Valid rises on the same edge as any bit held high through reset commits.
    if (tick && settle_q == TLAST) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pcnt_q    <= '0;
      settle_q  <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sw_raw;
      sync2_q   <= sync1_q;
      pcnt_q    <= pcnt_d;
      settle_q  <= settle_d;
      valid_q   <= valid_d;
      changed_q <= |commit;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .din    (sync2_q[i]),
      .dout   (sw_clean[i]),
      .commit (commit[i])
    );
  end

  assign sw_changed = changed_q;
  assign sw_valid   = valid_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: a tick-window reference model feeds a per-cycle
// expectation queue that a negedge monitor drains, plus directed timing checks.
module tb_switch_debouncer;

  localparam int unsigned W    = 8;
  localparam int unsigned DIV  = 4;
  localparam int unsigned STAB = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean;
  logic         sw_changed;
  logic         sw_valid;

  int checks = 0;
  int errors = 0;
  int changed_cnt = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH         (W),
    .SAMPLE_DIV    (DIV),
    .STABLE_SAMPLES(STAB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_changed(sw_changed),
    .sw_valid  (sw_valid)
  );

  typedef struct packed {
    logic [W-1:0] clean;
    logic         changed;
    logic         valid;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: raw value reaches the debounce logic two edges late;
  // every DIV-th edge after release takes a sample; a bit flips when the
  // last STAB samples since reset all disagree with it.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] samples[$];
  logic [W-1:0] m_clean;
  logic         m_changed;
  logic         m_valid;
  int           m_k;
  int           m_ticks;

  always @(posedge clk) begin
    logic [W-1:0] sync_val;
    logic [W-1:0] nxt;
    bit           flip;
    exp_t         e;
    if (!reset_n) begin
      raw_hist.delete();
      samples.delete();
      m_clean   = '0;
      m_changed = 1'b0;
      m_valid   = 1'b0;
      m_k       = 0;
      m_ticks   = 0;
    end else begin
      m_k++;
      sync_val = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : '0;
      nxt = m_clean;
      if (m_k % DIV == 0) begin
        samples.push_back(sync_val);
        if (samples.size() > STAB) void'(samples.pop_front());
        m_ticks++;
        if (samples.size() == STAB) begin
          for (int i = 0; i < W; i++) begin
            flip = 1'b1;
            for (int j = 0; j < STAB; j++) begin
              if (samples[j][i] == m_clean[i]) flip = 1'b0;
            end
            if (flip) nxt[i] = ~m_clean[i];
          end
        end
        if (m_ticks >= STAB) m_valid = 1'b1;
      end
      m_changed = (nxt != m_clean);
      m_clean   = nxt;
      raw_hist.push_back(sw_raw);
      if (raw_hist.size() > 4) void'(raw_hist.pop_front());
    end
    e.clean   = m_clean;
    e.changed = m_changed;
    e.valid   = m_valid;
    exp_q.push_back(e);
  end

  // Monitor: one expectation per clock, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({sw_clean, sw_changed, sw_valid} !== e) begin
        errors++;
        $display("FAIL model_cycle t=%0t got clean=%h chg=%b vld=%b want clean=%h chg=%b vld=%b",
                 $time, sw_clean, sw_changed, sw_valid, e.clean, e.changed, e.valid);
      end
    end
    if (sw_changed === 1'b1) changed_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    #1 sw_raw = v;
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    sw_raw  = v;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Counts edges from reset release until sw_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (sw_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // 1: quiet reset
    do_reset(8'h00);
    changed_cnt = 0;
    wait_valid(n);
    check("t1_valid_edge", n, 12);
    check("t1_clean", 32'(sw_clean), 32'h00);
    repeat (10) @(negedge clk);
    check("t1_no_changed", changed_cnt, 0);

    // 2: switches held through reset commit with valid
    do_reset(8'hA5);
    changed_cnt = 0;
    wait_valid(n);
    check("t2_valid_edge", n, 12);
    check("t2_clean", 32'(sw_clean), 32'hA5);
    check("t2_changed_same_edge", 32'(sw_changed), 1);
    repeat (10) @(negedge clk);
    check("t2_one_pulse", changed_cnt, 1);

    // 3: bounce on bit 0, then settle high
    do_reset(8'h00);
    wait_valid(n);
    changed_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      drive(sw_raw ^ 8'h01);
      repeat (4) @(negedge clk);
    end
    check("t3_bounce_hold", 32'(sw_clean[0]), 0);
    check("t3_bounce_no_pulse", changed_cnt, 0);
    drive(8'h01);
    n = 0;
    while (sw_clean[0] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check("t3_latency_le_14", 32'(n <= 14), 1);
    check("t3_latency_ge_11", 32'(n >= 11), 1);
    repeat (10) @(negedge clk);
    check("t3_one_pulse", changed_cnt, 1);

    // 4: short pulse falling between ticks is ignored
    do_reset(8'h00);
    wait_valid(n);
    changed_cnt = 0;
    n = 0;
    @(negedge clk);
    while (m_k % DIV != 2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1 sw_raw = 8'h08;
    @(negedge clk);
    @(negedge clk);
    #1 sw_raw = 8'h00;
    repeat (20) @(negedge clk);
    check("t4_clean", 32'(sw_clean), 32'h00);
    check("t4_no_changed", changed_cnt, 0);

    // 5: simultaneous multi-bit commit
    changed_cnt = 0;
    drive(8'h3C);
    repeat (20) @(negedge clk);
    check("t5_clean", 32'(sw_clean), 32'h3C);
    check("t5_one_pulse", changed_cnt, 1);

    // 6: reset mid-window discards partial counts
    drive(8'hFF);
    repeat (8) @(negedge clk);
    check("t6_pre_valid", 32'(sw_valid), 1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_async_clean", 32'(sw_clean), 0);
    check("t6_async_valid", 32'(sw_valid), 0);
    check("t6_async_changed", 32'(sw_changed), 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    changed_cnt = 0;
    wait_valid(n);
    check("t6_valid_edge", n, 12);
    check("t6_clean", 32'(sw_clean), 32'hFF);
    repeat (5) @(negedge clk);
    check("t6_one_pulse", changed_cnt, 1);

    // 7: random levels with random hold times
    for (int s = 0; s < 80; s++) begin
      drive(W'($urandom));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
